score_overlay_renderer: RTL

//   Multi-digit decimal score overlay for the VGA sprite display. Holds a binary score, converts it
//   to BCD with a sequential double-dabble engine, and renders NUM_DIGITS scaled 8x8 glyphs at a

---
 rtl/score_overlay_renderer_if.sv | 10 +
 rtl/score_overlay_renderer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/score_overlay_renderer_if.sv
// Register bus for the score overlay: a single-cycle write strobe qualified by chipselect.
interface score_overlay_renderer_if;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;

    modport master (output chipselect, write, address, writedata);
    modport slave  (input  chipselect, write, address, writedata);
endinterface

// File: rtl/score_overlay_renderer.sv
// Decimal score overlay: binary score -> sequential double-dabble BCD -> frame-synchronous
// digit latch -> two-stage glyph renderer with leading-zero blanking.
module score_overlay_renderer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCORE_W    = 14,
    parameter int SCALE_LOG2 = 1,
    parameter int VACTIVE    = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    score_overlay_renderer_if.slave  bus,
    input  logic [10:0]              hcount,
    input  logic [9:0]               vcount,
    output logic                     ovl_on,
    output logic [23:0]              ovl_rgb,
    output logic                     busy
);
    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BOX_W   = (NUM_DIGITS * 8) << SCALE_LOG2;
    localparam int BOX_H   = 8 << SCALE_LOG2;
    localparam int HACTIVE = 640;
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} cvt_state_t;

    cvt_state_t           state, state_nxt;
    logic [SCORE_W-1:0]   score, score_nxt, bin;
    logic [SCORE_W:0]     sum;
    logic [BCD_W-1:0]     bcd, bcd_adj, shadow, disp;
    logic [CNT_W-1:0]     cnt;
    logic [10:0]          xpos;
    logic [9:0]           ypos;
    logic [23:0]          color;
    logic                 enable, wr, start, frame_start;
    logic                 unused_bits;

    assign wr          = bus.chipselect && bus.write;
    assign frame_start = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
    assign unused_bits = ^bus.writedata[31:24];

    // Score update; ADD is evaluated one bit wider so the clamp sees any carry.
    always_comb begin
        score_nxt = score;
        start     = 1'b0;
        sum       = {1'b0, score} + (SCORE_W+1)'(bus.writedata[7:0]);
        if (wr) begin
            case (bus.address)
                3'd0: begin
                    score_nxt = (bus.writedata[SCORE_W-1:0] > MAX_SCORE) ?
                                MAX_SCORE : bus.writedata[SCORE_W-1:0];
                    start     = 1'b1;
                end
                3'd1: begin
                    score_nxt = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[SCORE_W-1:0];
                    start     = 1'b1;
                end
                3'd5: begin
                    if (bus.writedata[1]) begin
                        score_nxt = '0;
                        start     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score  <= '0;
            xpos   <= 11'd8;
            ypos   <= 10'd8;
            color  <= 24'hFFFFFF;
            enable <= 1'b1;
        end else begin
            score <= score_nxt;
            if (wr) begin
                case (bus.address)
                    3'd2:    xpos   <= bus.writedata[10:0];
                    3'd3:    ypos   <= bus.writedata[9:0];
                    3'd4:    color  <= bus.writedata[23:0];
                    3'd5:    enable <= bus.writedata[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A new score always restarts SHIFT, even from DONE, so shadow only sees whole results.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            SHIFT:   if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = SHIFT;
    end

    for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_adj
        assign bcd_adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            shadow <= '0;
        end else if (start) begin
            bin <= score_nxt;
            bcd <= '0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            bcd <= {bcd_adj[BCD_W-2:0], bin[SCORE_W-1]};
            bin <= bin << 1;
            cnt <= cnt + 1'b1;
        end else if (state == DONE) begin
            shadow <= bcd;
        end
    end

    // Display digits change only at the frame strobe; the NBA gives it the pre-update shadow.
    always_ff @(posedge clk) begin
        if (reset)            disp <= '0;
        else if (frame_start) disp <= shadow;
    end

    // vis[i] for box digit i (0 = most significant): any nibble at or above it is nonzero.
    logic [NUM_DIGITS-1:0] vis;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_vis
        if (i == NUM_DIGITS - 1) begin : g_ls
            assign vis[i] = 1'b1;
        end else begin : g_ms
            assign vis[i] = |disp[BCD_W-1 -: 4*(i+1)];
        end
    end

    function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
        logic [63:0] g;
        case (d)
            4'd0:    g = 64'h3C666E7666663C00;
            4'd1:    g = 64'h1838181818187E00;
            4'd2:    g = 64'h3C66060C30607E00;
            4'd3:    g = 64'h3C66061C06663C00;
            4'd4:    g = 64'h0C1C3C6C7E0C0C00;
            4'd5:    g = 64'h7E607C0606663C00;
            4'd6:    g = 64'h3C66607C66663C00;
            4'd7:    g = 64'h7E660C1818181800;
            4'd8:    g = 64'h3C66663C66663C00;
            4'd9:    g = 64'h3C66663E06663C00;
            default: g = '0;
        endcase
        return g[8*(7-r) +: 8];
    endfunction

    logic [11:0]      x_end;
    logic [10:0]      y_end, dx, dy_ext;
    logic [9:0]       dy;
    logic             in_box, s1_in, s2_on, vis_sel;
    logic [DIG_W-1:0] s1_dig;
    logic [2:0]       s1_row, s1_col;
    logic [3:0]       nib;
    logic [7:0]       row_bits;

    // Wide end coordinates so a box near the right/bottom edge clips instead of wrapping.
    assign x_end  = 12'(xpos) + 12'(BOX_W);
    assign y_end  = 11'(ypos) + 11'(BOX_H);
    assign in_box = (hcount >= xpos) && (12'(hcount) < x_end) && (hcount < 11'(HACTIVE)) &&
                    (vcount >= ypos) && (11'(vcount) < y_end) && (vcount < 10'(VACTIVE));
    assign dx     = hcount - xpos;
    assign dy     = vcount - ypos;
    assign dy_ext = 11'(dy);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_in  <= 1'b0;
            s1_dig <= '0;
            s1_row <= '0;
            s1_col <= '0;
            s2_on  <= 1'b0;
        end else begin
            s1_in  <= in_box;
            s1_dig <= DIG_W'(dx >> (3 + SCALE_LOG2));
            s1_col <= 3'(dx >> SCALE_LOG2);
            s1_row <= 3'(dy_ext >> SCALE_LOG2);
            s2_on  <= s1_in && vis_sel && row_bits[3'd7 - s1_col];
        end
    end

    always_comb begin
        nib     = '0;
        vis_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s1_dig == DIG_W'(i)) begin
                nib     = disp[4*(NUM_DIGITS-1-i) +: 4];
                vis_sel = vis[i];
            end
        end
        row_bits = font_row(nib, s1_row);
    end

    assign ovl_on  = s2_on && enable;
    assign ovl_rgb = ovl_on ? color : 24'h0;
endmodule
